// File: rtl/dau_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : dau_instr_queue
// Purpose  : In-order instruction buffer between the DAU micro-sequencers
//            (add/sub/mul/div) and the BCD unit executor. Sequencers push
//            16-bit BCDU instructions; the head is presented to the BCDU
//            with a valid/ready handshake.
// Ports    : i_clk, i_rst            clock (rising), async active-high reset
//            i_instr_valid, i_instr  sequencer push
//            o_instr_accept          a push in the next cycle is guaranteed
//                                    a slot (one slot of lookahead)
//            o_instr_valid, o_instr  head entry to the BCDU
//            i_bcdu_ready            BCDU consumes the head this cycle
//            o_level, o_empty        fill level / level==0
//            o_overflow              sticky, set when a push is dropped
// Options  : DAU_INSTR_QUEUE_BYPASS_EN - when defined, a push into an empty
//            queue is presented to the BCDU in the same cycle and is not
//            stored if the BCDU takes it immediately.
// Revision : 1.0 - initial release
// ============================================================================
module dau_instr_queue #(
    parameter int DEPTH   = 4,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_instr_valid,
    input  logic [15:0]        i_instr,
    output logic               o_instr_accept,
    output logic               o_instr_valid,
    output logic [15:0]        o_instr,
    input  logic               i_bcdu_ready,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_empty,
    output logic               o_overflow
);

    localparam int                 PTR_W   = $clog2(DEPTH);
    localparam logic [LEVEL_W-1:0] C_DEPTH = LEVEL_W'(DEPTH);

    logic [15:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] count_q,  count_d;
    logic               overflow_q, overflow_d;

    logic w_stored;    // head comes from the array
    logic w_bypass;    // head comes straight from the sequencer
    logic w_pop_mem;   // stored head consumed this cycle
    logic w_full;
    logic w_write;

    always_comb begin
        w_stored = (count_q != '0);
`ifdef DAU_INSTR_QUEUE_BYPASS_EN
        w_bypass = (count_q == '0) & i_instr_valid;
`else
        w_bypass = 1'b0;
`endif
        w_full    = (count_q == C_DEPTH);
        w_pop_mem = w_stored & i_bcdu_ready;
        // A full queue still accepts a push when the head leaves in the same
        // cycle; a bypassed instruction taken immediately is never stored.
        w_write   = i_instr_valid & (~w_full | w_pop_mem)
                  & ~(w_bypass & i_bcdu_ready);

        count_d    = count_q + LEVEL_W'(w_write) - LEVEL_W'(w_pop_mem);
        wr_ptr_d   = w_write   ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop_mem ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        overflow_d = overflow_q | (i_instr_valid & w_full & ~w_pop_mem);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array is not reset; its contents only matter while count != 0.
    always_ff @(posedge i_clk) begin
        if (w_write) begin
            mem_q[wr_ptr_q] <= i_instr;
        end
    end

    // Accept looks only at the current count and the push in flight, never at
    // i_bcdu_ready, so there is no combinational path through the BCDU.
    assign o_instr_accept = (count_q + LEVEL_W'(i_instr_valid)) < C_DEPTH;
    assign o_instr_valid  = w_stored | w_bypass;
    assign o_instr        = w_bypass ? i_instr : mem_q[rd_ptr_q];
    assign o_level        = count_q;
    assign o_empty        = (count_q == '0);
    assign o_overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_dau_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_dau_instr_queue
// Purpose  : Self-checking bench for dau_instr_queue (DEPTH=4). A queue-based
//            reference model is compared against the DUT every cycle, and
//            directed scenarios carry hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dau_instr_queue;

    localparam int DEPTH   = 4;
    localparam int LEVEL_W = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic [15:0]        in_instr = 16'h0;
    logic               ready = 1'b0;
    logic               accept, out_valid, empty, overflow;
    logic [15:0]        out_instr;
    logic [LEVEL_W-1:0] level;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dau_instr_queue #(.DEPTH(DEPTH), .LEVEL_W(LEVEL_W)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_instr_valid  (in_valid),
        .i_instr        (in_instr),
        .o_instr_accept (accept),
        .o_instr_valid  (out_valid),
        .o_instr        (out_instr),
        .i_bcdu_ready   (ready),
        .o_level        (level),
        .o_empty        (empty),
        .o_overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] mq[$];      // stored entries, head at index 0
    logic [15:0] taken[$];   // everything the BCDU consumed, in order
    bit          m_ovf = 1'b0;
    bit          bypass_build;

    initial begin
`ifdef DAU_INSTR_QUEUE_BYPASS_EN
        bypass_build = 1'b1;
`else
        bypass_build = 1'b0;
`endif
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            int  sz;
            bit  popped;
            sz     = mq.size();
            popped = 1'b0;
            if (bypass_build && sz == 0 && in_valid && ready) begin
                taken.push_back(in_instr);
            end else begin
                if (sz != 0 && ready) begin
                    taken.push_back(mq.pop_front());
                    popped = 1'b1;
                end
                if (in_valid) begin
                    if (sz < DEPTH || popped) mq.push_back(in_instr);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int  sz;
            bit  exp_valid;
            logic [15:0] exp_head;
            sz        = mq.size();
            exp_valid = (sz != 0) || (bypass_build && in_valid);
            exp_head  = (sz != 0) ? mq[0] : in_instr;
            chk("level",    32'(level),    32'(sz));
            chk("empty",    32'(empty),    32'(sz == 0));
            chk("valid",    32'(out_valid), 32'(exp_valid));
            chk("accept",   32'(accept),   32'((sz + int'(in_valid)) < DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (exp_valid) chk("head", 32'(out_instr), 32'(exp_head));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [15:0] d, input logic r);
        @(posedge clk);
        #1;
        in_valid = v;
        in_instr = d;
        ready    = r;
    endtask

    task automatic chk_taken(input string name, input logic [15:0] exp[$]);
        chk({name, "_len"}, 32'(taken.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < taken.size(); i++) begin
            chk(name, 32'(taken[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        logic [15:0] e[$];

        // Reset state
        #12;
        chk("rst_valid",  32'(out_valid), 32'h0);
        chk("rst_empty",  32'(empty),     32'h1);
        chk("rst_level",  32'(level),     32'h0);
        chk("rst_accept", 32'(accept),    32'h1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single push of 16'h3700 with the BCDU ready
        step(1'b1, 16'h3700, 1'b1);
`ifdef DAU_INSTR_QUEUE_BYPASS_EN
        chk("byp_valid", 32'(out_valid), 32'h1);
        chk("byp_instr", 32'(out_instr), 32'h3700);
        step(1'b0, 16'h0, 1'b1);
        chk("byp_level", 32'(level), 32'h0);
`else
        step(1'b0, 16'h0, 1'b1);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_instr", 32'(out_instr), 32'h3700);
        step(1'b0, 16'h0, 1'b1);
        chk("t1_empty", 32'(empty), 32'h1);
`endif
        step(1'b0, 16'h0, 1'b0);
        taken.delete();

        // Fill four entries with the BCDU stalled
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h1001 + 16'(i), 1'b0);
            chk("fill_accept", 32'(accept), (i == 3) ? 32'h0 : 32'h1);
        end
        step(1'b0, 16'h0, 1'b0);
        chk("full_level", 32'(level),    32'h4);
        chk("full_ovf",   32'(overflow), 32'h0);
        chk("full_acc",   32'(accept),   32'h0);

        // Push and pop together while full
        step(1'b1, 16'h5A70, 1'b1);
        step(1'b0, 16'h0, 1'b0);
        chk("pp_level", 32'(level),    32'h4);
        chk("pp_ovf",   32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b0);
        e = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h5A70};
        chk_taken("drain_order", e);
        taken.delete();

        // Forced push into a full queue is dropped
        for (int i = 0; i < 4; i++) step(1'b1, 16'h4400 + 16'(i), 1'b0);
        step(1'b1, 16'hDEAD, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        chk("drop_ovf",   32'(overflow), 32'h1);
        chk("drop_level", 32'(level),    32'h4);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b0);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        e = '{16'h4400, 16'h4401, 16'h4402, 16'h4403};
        chk_taken("drop_order", e);
        taken.delete();

        // Reset clears overflow, then stream 12 instructions back to back
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("rst2_ovf", 32'(overflow), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b1, 16'h2000 + 16'(i), 1'b1);
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b0);
        e.delete();
        for (int i = 0; i < 12; i++) e.push_back(16'h2000 + 16'(i));
        chk_taken("stream_order", e);
        chk("stream_ovf", 32'(overflow), 32'h0);

        // Asynchronous reset with three entries buffered
        for (int i = 0; i < 3; i++) step(1'b1, 16'h7700 + 16'(i), 1'b0);
        step(1'b0, 16'h0, 1'b0);
        chk("pre_rst_level", 32'(level), 32'h3);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid",  32'(out_valid), 32'h0);
        chk("arst_level",  32'(level),     32'h0);
        chk("arst_empty",  32'(empty),     32'h1);
        chk("arst_accept", 32'(accept),    32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dau_instr_queue.md
Name: dau_instr_queue

Overview:
- Instruction buffer between the DAU micro-sequencers (add/sub/mul/div) and the BCD unit (BCDU) executor.
- Absorbs 16-bit BCDU instructions pushed by a sequencer and presents them in order to the BCDU with a valid/ready handshake.
- Generates the sequencer-side accept signal. A sequencer samples accept in cycle t and pushes the resulting instruction in cycle t+1, so accept must reserve one slot of lookahead.

Parameters:
- DEPTH, 4, number of instruction entries; power of two, minimum 2.
- LEVEL_W, $clog2(DEPTH)+1, width of the fill-level counter and of o_level.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_instr_valid  in  1  sequencer pushes i_instr this cycle.
- i_instr  in  16  instruction: opcode [15:12], operand fields [11:0].
- o_instr_accept  out  1  sequencer may advance; a push in the next cycle is guaranteed a slot.
- o_instr_valid  out  1  head entry available to the BCDU.
- o_instr  out  16  head instruction.
- i_bcdu_ready  in  1  BCDU consumes the head this cycle when o_instr_valid=1.
- o_level  out  LEVEL_W  current number of stored entries.
- o_empty  out  1  o_level==0.
- o_overflow  out  1  sticky; set when a push is dropped.

Behaviour:
- Storage: circular buffer with wr_ptr and rd_ptr (log2(DEPTH) bits each, wrapping modulo DEPTH) and a count register (0..DEPTH).
- push = i_instr_valid. pop = o_instr_valid & i_bcdu_ready.
- Entry write:
  - Entry written when push & (count<DEPTH | pop).
  - Push and pop in the same cycle when full: both take effect, count unchanged.
- Count update: count_next = count + written - pop.
- Dropped push (push & count==DEPTH & ~pop): instruction discarded, o_overflow set to 1, held until reset.
- o_instr_accept = (count + i_instr_valid) < DEPTH.
  - Combinational from count and i_instr_valid only; no dependence on i_bcdu_ready, so no combinational loop through the BCDU.
  - Conservative: ignores a concurrent pop.
- o_instr_valid = (count != 0). o_instr = mem[rd_ptr].
- Latency: push in cycle t appears at o_instr_valid in cycle t+1 when the queue was empty.
- Ordering: strict FIFO. Instructions from different sequencers are not reordered.
- Pop when empty: ignored, since o_instr_valid=0.
- Reset values (asynchronous, effective immediately):
  - count=0, wr_ptr=0, rd_ptr=0, o_overflow=0.
  - Result: o_instr_valid=0, o_empty=1, o_level=0, o_instr_accept=1.
  - Memory contents need not be reset. o_instr reads the array (value unspecified) while o_instr_valid=0.
- Reset mid-operation: all buffered instructions are discarded. No partial pops or pushes complete.
- An accepting sequencer never causes an overflow. Overflow indicates only a protocol violation by an upstream block.

Optional Feature:
- Macro: DAU_INSTR_QUEUE_BYPASS_EN.
- When defined, the empty queue is cut through:
  - If count==0 and i_instr_valid=1: o_instr_valid=1 and o_instr=i_instr in the same cycle.
  - If i_bcdu_ready=1 in that cycle, the instruction is not stored (count stays 0).
  - Otherwise it is written as normal.
- Zero-cycle latency when empty. o_instr_valid and o_instr gain a combinational path from i_instr_valid and i_instr.
- When undefined: fully registered output, one-cycle minimum latency.
- Accept, overflow and ordering rules are identical in both builds.

Test Plan:
- Reset, then a single push of 16'h3700 with i_bcdu_ready=1:
  - Next cycle: o_instr_valid=1, o_instr=16'h3700.
  - Cycle after: o_empty=1.
  - With BYPASS_EN: o_instr_valid=1 in the push cycle and o_level stays 0.
- DEPTH=4, i_bcdu_ready=0, push 4 instructions while honoring accept:
  - o_instr_accept=0 once count+valid reaches 4.
  - o_level=4, o_overflow=0.
  - Draining pops 4 instructions in push order.
- Full queue with a forced push and i_bcdu_ready=0: instruction dropped, o_overflow=1 and stays 1, o_level=4.
- Full queue with simultaneous push 16'h5A70 and pop:
  - o_level remains 4, o_overflow=0.
  - 16'h5A70 emerges last after the other 3.
- Back-to-back push/pop streaming of 12 instructions with i_bcdu_ready=1 continuously:
  - wr_ptr/rd_ptr wrap 3 times.
  - Output order matches input order, no drops.
- Assert i_rst with o_level=3 mid-clock:
  - o_instr_valid=0 and o_level=0 immediately, without waiting for a clock edge.
  - o_instr_accept=1 once i_instr_valid=0.
